// File: rtl/decoder_pkg.sv
// ----------------------------------------------------------------------------
// decoder_pkg
// Shared types and helpers for the registered N-to-2^N decoder.
//   state_e      : decoder FSM states (idle / hold a decoded code / scan)
//   MODE_DIRECT  : i_mode value selecting direct decode
//   MODE_SCAN    : i_mode value selecting autonomous scan
//   onehot()     : one-hot of an index, sized for the widest supported decoder;
//                  callers size-cast the result down to their own OUT_W.
// ----------------------------------------------------------------------------
package decoder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StScan
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest decoder the helper can serve (SEL_W must not exceed this).
    localparam int unsigned MAX_SEL_W = 8;
    localparam int unsigned MAX_OUT_W = 1 << MAX_SEL_W;

    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        logic [MAX_OUT_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decoder_scan_ctr.sv
// ----------------------------------------------------------------------------
// decoder_scan_ctr
// Index and dwell counters for the decoder scan mode, plus the wrap pulse.
//   i_clk    : system clock, rising edge
//   i_rst    : asynchronous active-high reset
//   i_clear  : restart the scan: index 0, dwell counter loaded from i_dwell
//   i_run    : scan is progressing this cycle
//   i_dwell  : dwell count; each index is held i_dwell+1 cycles
//   o_idx    : current scan index
//   o_wrap   : one-cycle pulse on the cycle the index returns to 0
//   o_step   : index advances at the coming edge (combinational)
// ----------------------------------------------------------------------------
module decoder_scan_ctr #(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned DWELL_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_run,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [SEL_W-1:0]   o_idx,
    output logic               o_wrap,
    output logic               o_step
);

    logic [SEL_W-1:0]   r_idx;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_wrap;
    logic               w_step;

    assign w_step = i_run & ~i_clear & (r_cnt == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx  <= '0;
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (i_clear) begin
            r_idx  <= '0;
            r_cnt  <= i_dwell;
            r_wrap <= 1'b0;
        end else if (i_run) begin
            if (r_cnt == '0) begin
                // Dwell is re-sampled at every step so it can be changed on the fly.
                r_idx  <= r_idx + 1'b1;
                r_cnt  <= i_dwell;
                r_wrap <= (r_idx == {SEL_W{1'b1}});
            end else begin
                r_cnt  <= r_cnt - 1'b1;
                r_wrap <= 1'b0;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign o_idx  = r_idx;
    assign o_wrap = r_wrap;
    assign o_step = w_step;

endmodule

// File: rtl/decoder_nto2n_seq.sv
// ----------------------------------------------------------------------------
// decoder_nto2n_seq
// Registered N-to-2^N one-hot decoder with enable, valid/ready input handshake
// and an autonomous scan mode that walks the one-hot across all outputs.
//   i_clk       : system clock, rising edge
//   i_rst       : asynchronous active-high reset
//   i_en        : enable; 0 forces the outputs inactive and aborts a scan
//   i_mode      : 0 = direct decode, 1 = scan
//   i_in_valid  : i_sel is valid (direct mode)
//   o_in_ready  : sel is accepted this cycle (en & ~mode & ~rst)
//   i_sel       : code to decode
//   i_dwell     : scan dwell; each index is held dwell+1 cycles
//   o_out       : registered one-hot output
//   o_out_valid : o_out holds a decoded or scan value
//   o_scan_wrap : one-cycle pulse when the scan returns to index 0
// Build option: DECODER_ACTIVE_LOW_EN drives o_out one-cold (inactive = all ones).
// ----------------------------------------------------------------------------
module decoder_nto2n_seq
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned DWELL_W = 4,
    localparam int unsigned OUT_W  = 2 ** SEL_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_mode,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [SEL_W-1:0]   i_sel,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [OUT_W-1:0]   o_out,
    output logic               o_out_valid,
    output logic               o_scan_wrap
);

    state_e             r_state;
    state_e             w_state_d;
    logic [OUT_W-1:0]   r_hot;
    logic [OUT_W-1:0]   w_hot_d;
    logic               r_out_valid;
    logic               w_xfer;
    logic               w_scan_run;
    logic [SEL_W-1:0]   w_idx;
    logic [SEL_W-1:0]   w_idx_nxt;
    logic               w_step;
    logic               w_wrap;

    assign o_in_ready = i_en & (i_mode == MODE_DIRECT) & ~i_rst;
    assign w_xfer     = i_in_valid & o_in_ready;

    // The scan counters only advance while we stay in scan; any other path
    // (entry, exit, disable) restarts them at index 0.
    assign w_scan_run = (r_state == StScan) & (w_state_d == StScan);
    assign w_idx_nxt  = w_idx + 1'b1;

    decoder_scan_ctr #(
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W)
    ) u_scan_ctr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (~w_scan_run),
        .i_run   (w_scan_run),
        .i_dwell (i_dwell),
        .o_idx   (w_idx),
        .o_wrap  (w_wrap),
        .o_step  (w_step)
    );

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_hot       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_hot       <= w_hot_d;
            r_out_valid <= (w_state_d != StIdle);
        end
    end

    // Next state, in priority order: disable, enter scan, leave scan, transfer.
    always_comb begin
        w_state_d = r_state;
        if (!i_en) begin
            w_state_d = StIdle;
        end else if ((i_mode == MODE_SCAN) && (r_state != StScan)) begin
            w_state_d = StScan;
        end else if ((i_mode == MODE_DIRECT) && (r_state == StScan)) begin
            w_state_d = StIdle;
        end else if (w_xfer) begin
            w_state_d = StHold;
        end
    end

    // Next one-hot value for the output register.
    always_comb begin
        w_hot_d = r_hot;
        unique case (w_state_d)
            StIdle: w_hot_d = '0;
            StHold: begin
                if (w_xfer) begin
                    w_hot_d = OUT_W'(onehot(MAX_SEL_W'(i_sel)));
                end
            end
            StScan: begin
                if (r_state != StScan) begin
                    w_hot_d = OUT_W'(onehot(MAX_SEL_W'(0)));
                end else if (w_step) begin
                    w_hot_d = OUT_W'(onehot(MAX_SEL_W'(w_idx_nxt)));
                end
            end
            default: w_hot_d = '0;
        endcase
    end

`ifdef DECODER_ACTIVE_LOW_EN
    assign o_out = ~r_hot;
`else
    assign o_out = r_hot;
`endif
    assign o_out_valid = r_out_valid;
    assign o_scan_wrap = w_wrap;

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
module tb_decoder_nto2n_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] sel = 3'd0;
    logic [3:0] dwell = 4'd0;
    logic       in_ready;
    logic [7:0] out;
    logic       out_valid;
    logic       scan_wrap;

    int total = 0;
    int bad   = 0;

    logic [7:0] hot_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    // Behavioural model: 0 idle, 1 holding m_sel, 2 scanning at m_idx.
    int m_st, m_sel, m_idx, m_age, m_dw;
    bit m_wrap;

    always #5 clk = ~clk;

    decoder_nto2n_seq #(
        .SEL_W   (3),
        .DWELL_W (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_mode      (mode),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_sel       (sel),
        .i_dwell     (dwell),
        .o_out       (out),
        .o_out_valid (out_valid),
        .o_scan_wrap (scan_wrap)
    );

    function automatic logic [7:0] pol(input logic [7:0] v);
`ifdef DECODER_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_st = 0; m_sel = 0; m_idx = 0; m_age = 0; m_dw = 0; m_wrap = 1'b0;
    endtask

    task automatic m_step();
        m_wrap = 1'b0;
        if (!en) begin
            m_st = 0;
        end else if (mode && m_st != 2) begin
            m_st = 2; m_idx = 0; m_age = 0; m_dw = int'(dwell);
        end else if (!mode && m_st == 2) begin
            m_st = 0;
        end else if (in_valid && !mode) begin
            m_st = 1; m_sel = int'(sel);
        end else if (m_st == 2) begin
            // Each index is shown for (dwell sampled when it began)+1 cycles.
            if (m_age >= m_dw) begin
                m_idx  = (m_idx + 1) % 8;
                m_age  = 0;
                m_dw   = int'(dwell);
                m_wrap = (m_idx == 0);
            end else begin
                m_age++;
            end
        end
    endtask

    function automatic logic [7:0] m_hot();
        logic [7:0] v;
        v = 8'h00;
        if (m_st == 1) v = 8'd1 << m_sel;
        if (m_st == 2) v = 8'd1 << m_idx;
        return v;
    endfunction

    // Per-cycle comparison against the model, plus immediately on async reset.
    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
            #1;
            chk("out", 32'(out), 32'(pol(m_hot())));
            chk("out_valid", 32'(out_valid), 32'(m_st != 0));
            chk("scan_wrap", 32'(scan_wrap), 32'(m_wrap));
            chk("in_ready", 32'(in_ready), 32'(en & ~mode & ~rst));
        end
    end

    initial begin
        // Reset values; ready stays low while reset is high even if enabled.
        @(negedge clk);
        en = 1'b1; mode = 1'b0; in_valid = 1'b1;
        #1;
        chk("rst_out", 32'(out), 32'(pol(8'h00)));
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back transfers of every code.
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            @(negedge clk);
            chk("t1_out", 32'(out), 32'(pol(hot_tab[i])));
            chk("t1_ready", 32'(in_ready), 32'd1);
        end

        // Disabled: no transfer, outputs inactive; then re-enable and transfer.
        en = 1'b0; sel = 3'd5;
        #1;
        chk("t2_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("t2_out_off", 32'(out), 32'(pol(8'h00)));
        chk("t2_valid_off", 32'(out_valid), 32'd0);
        en = 1'b1;
        @(negedge clk);
        chk("t2_out_on", 32'(out), 32'(pol(8'h20)));
        in_valid = 1'b0;

        // Scan with dwell=2 and in_valid noise; wrap exactly on the return to 01.
        mode = 1'b1; dwell = 4'd2; in_valid = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            sel = 3'($urandom_range(0, 7));
            chk("t3_out", 32'(out), 32'(pol(k < 24 ? hot_tab[k / 3] : 8'h01)));
            chk("t3_wrap", 32'(scan_wrap), 32'(k == 24));
        end

        // Scan with dwell=0, abort at index 5, re-entry restarts at 0.
        mode = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        mode = 1'b1; dwell = 4'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t4_out", 32'(out), 32'(pol(hot_tab[k])));
        end
        en = 1'b0;
        @(negedge clk);
        chk("t4_abort", 32'(out), 32'(pol(8'h00)));
        en = 1'b1;
        @(negedge clk);
        chk("t4_restart", 32'(out), 32'(pol(8'h01)));

        // Async reset mid-hold clears without a clock edge.
        mode = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; sel = 3'd4;
        @(negedge clk);
        chk("t5_hold", 32'(out), 32'(pol(8'h10)));
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_out", 32'(out), 32'(pol(8'h00)));
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomised traffic against the model.
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 99) == 0);
            en       = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            in_valid = $urandom_range(0, 1) == 1;
            sel      = 3'($urandom_range(0, 7));
            dwell    = 4'($urandom_range(0, 3));
        end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
